// File: rtl/asrm_mem_bus.sv
// Memory interconnect: base/mask decode to NSLAVE regions, per-region wait states,
// registered read data, one-cycle ready pulse and sticky bus error for unmapped accesses.
module asrm_mem_bus #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16,
    parameter int NSLAVE    = 4,
    parameter logic [NSLAVE*ADDR_SIZE-1:0] SLAVE_BASE = '0,
    parameter logic [NSLAVE*ADDR_SIZE-1:0] SLAVE_MASK = '0,
    parameter logic [NSLAVE*4-1:0]         SLAVE_WAIT = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpu_req,
    input  logic [ADDR_SIZE-1:0]        cpu_addr,
    input  logic [WORD_SIZE-1:0]        cpu_wdata,
    input  logic                        cpu_write_en,
    output logic [WORD_SIZE-1:0]        cpu_rdata,
    output logic                        cpu_ready,
    output logic                        bus_error,
    input  logic                        err_clear,
    output logic [NSLAVE-1:0]           slv_enable,
    output logic [ADDR_SIZE-1:0]        slv_addr,
    output logic [WORD_SIZE-1:0]        slv_wdata,
    output logic                        slv_write_en,
    input  logic [NSLAVE*WORD_SIZE-1:0] slv_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LATCH, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           wait_q, wait_d;
    logic                 first_q, first_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 hit;
    logic [3:0]           hit_idx;
    logic [3:0]           hit_wait;
    logic [ADDR_SIZE-1:0] sel_mask;
    logic [WORD_SIZE-1:0] sel_rdata;
    logic                 active;

    // Scan from the top so the lowest matching region is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if ((cpu_addr & SLAVE_MASK[i*ADDR_SIZE +: ADDR_SIZE]) == SLAVE_BASE[i*ADDR_SIZE +: ADDR_SIZE]) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    always_comb begin
        hit_wait  = '0;
        sel_mask  = '0;
        sel_rdata = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (hit_idx == 4'(i)) hit_wait = SLAVE_WAIT[i*4 +: 4];
            if (idx_q == 4'(i)) begin
                sel_mask  = SLAVE_MASK[i*ADDR_SIZE +: ADDR_SIZE];
                sel_rdata = slv_rdata[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        first_d = first_q;
        rdata_d = rdata_q;
        err_d   = err_clear ? 1'b0 : err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_write_en;
                    idx_d   = hit_idx;
                    wait_d  = hit ? hit_wait : 4'd0;
                    first_d = 1'b1;
                    if (hit) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_DONE;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                first_d = 1'b0;
                if (wait_q == 4'd0) state_d = S_LATCH;
                else                wait_d  = wait_q - 4'd1;
            end
            S_LATCH: begin
                rdata_d = sel_rdata;
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wait_q  <= '0;
            first_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            first_q <= first_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Slave side is decoded from registered state only, so reset silences it at once.
    assign active = (state_q == S_ACCESS) || (state_q == S_LATCH);

    always_comb begin
        for (int i = 0; i < NSLAVE; i++) begin
            slv_enable[i] = active && (idx_q == 4'(i));
        end
    end

    assign slv_addr     = active ? (addr_q & ~sel_mask) : '0;
    assign slv_wdata    = active ? wdata_q : '0;
    assign slv_write_en = (state_q == S_ACCESS) && first_q && we_q;
    assign cpu_ready    = (state_q == S_DONE);
    assign cpu_rdata    = rdata_q;
    assign bus_error    = err_q;

endmodule

// File: doc/asrm_mem_bus.md
Name: asrm_mem_bus

Overview:
- Parametrised memory interconnect between the asrm_cpu-style master port and NSLAVE synchronous memory or peripheral regions.
- Replaces hand-wired enable/OR decoding with:
  - a programmable base/mask address map,
  - per-region wait states,
  - a registered read-data mux,
  - a ready handshake,
  - a sticky bus-error flag for unmapped accesses.
- Sits at the top level between the CPU and its ROM, RAM and peripherals.

Parameters:
- WORD_SIZE, 16, data width in bits.
- ADDR_SIZE, 16, address width in bits.
- NSLAVE, 4, number of slave regions (1..16).
- SLAVE_BASE, 0, flat NSLAVE*ADDR_SIZE vector; slice i is the base address of region i.
- SLAVE_MASK, 0, flat NSLAVE*ADDR_SIZE vector; slice i is the decode mask of region i.
- SLAVE_WAIT, 0, flat NSLAVE*4 vector; slice i is the number of extra access cycles for region i (0..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access strobe; sampled only in IDLE.
- cpu_addr  in  ADDR_SIZE  access address.
- cpu_wdata  in  WORD_SIZE  write data.
- cpu_write_en  in  1  1 = write, 0 = read.
- cpu_rdata  out  WORD_SIZE  registered read data.
- cpu_ready  out  1  one-cycle completion pulse.
- bus_error  out  1  sticky flag: an unmapped access occurred.
- err_clear  in  1  synchronous clear of bus_error.
- slv_enable  out  NSLAVE  one-hot region select.
- slv_addr  out  ADDR_SIZE  offset within region, = latched addr & ~SLAVE_MASK[i].
- slv_wdata  out  WORD_SIZE  latched write data.
- slv_write_en  out  1  write strobe to the selected slave.
- slv_rdata  in  NSLAVE*WORD_SIZE  per-slave read data, slice i from slave i.

Behaviour:
- Decode:
  - Region i hits when (addr & SLAVE_MASK[i]) == SLAVE_BASE[i].
  - On multiple hits, the lowest index wins.
  - No hit means the access is unmapped.
- States: IDLE, ACCESS, LATCH, DONE. An unmapped access skips ACCESS and LATCH.
- IDLE:
  - On cpu_req=1, latch addr, wdata, write_en and the decoded index.
  - Load the wait counter with SLAVE_WAIT[i].
  - Mapped access → ACCESS; unmapped access → DONE.
- ACCESS:
  - slv_enable[i]=1; slv_addr and slv_wdata are driven.
  - slv_write_en=latched write_en in the first ACCESS cycle only, so each access produces exactly one write.
  - Stays 1+SLAVE_WAIT[i] cycles, counting down, then → LATCH.
- LATCH:
  - slv_enable[i] stays 1 and slv_write_en=0.
  - At the end of this cycle, cpu_rdata <= slv_rdata slice i. This is done for writes too, so rdata shows the slave's output.
  - → DONE.
- DONE:
  - cpu_ready=1 for exactly one cycle; all slv_* outputs are 0.
  - Unmapped access: cpu_rdata <= 0 on entry to DONE, bus_error <= 1, and nothing is driven to any slave.
  - → IDLE.
- cpu_rdata holds its value until the next LATCH or unmapped DONE.
- Latency, cpu_req accepted at edge 0:
  - Mapped: cpu_ready high in cycle 3+W.
  - Unmapped: cpu_ready high in cycle 1.
  - Peak throughput is one access per W+4 cycles.
- cpu_req is ignored outside IDLE; the master must hold off until cpu_ready.
- cpu_addr, cpu_wdata and cpu_write_en are don't-care after the accepting edge.
- bus_error:
  - Set by an unmapped access; cleared by err_clear.
  - If set and clear happen in the same cycle, set wins.
- Reset, at any time including mid-access:
  - State goes to IDLE.
  - cpu_rdata, cpu_ready, bus_error, slv_enable, slv_addr, slv_wdata and slv_write_en all go to 0.
  - The wait counter clears.
  - An interrupted write may or may not have reached the slave. No write strobe is issued after reset.
- slv_enable is never multi-hot; all slv_* outputs are 0 in IDLE.

Test Plan:
Common configuration: NSLAVE=2; region 0 = BASE 0x0000, MASK 0xFF80 (ROM, WAIT=0); region 1 = BASE 0x0080, MASK 0xFF80 (RAM, WAIT=2).
1. Read 0x0005, ROM word 0x1234 at offset 5 → slv_enable=01 for 2 cycles, slv_addr=0x0005, cpu_ready in cycle 3, cpu_rdata=0x1234.
2. Write 0xBEEF to 0x0083, then read 0x0083 → slv_enable=10 for 4 cycles, slv_addr=0x0003, slv_write_en high exactly 1 cycle, ready in cycle 5; the read returns 0xBEEF.
3. Read 0x0100 (unmapped) → no slv_enable, ready in cycle 1, cpu_rdata=0x0000, bus_error=1 and stays 1 across a later good access. Then err_clear=1 together with another unmapped access → bus_error remains 1; err_clear alone → 0.
4. Overlap config: region 0 MASK 0x0000 (matches all), region 1 as before; read 0x0083 → region 0 is selected, slv_addr=0x0083.
5. Assert reset during the second ACCESS cycle of a region-1 write → all outputs 0 immediately (asynchronous), no further write strobe; after release, a new read of 0x0005 completes normally in 3 cycles.
6. cpu_req held high continuously on alternating ROM/RAM reads → accesses complete every 4 and 6 cycles respectively; a cpu_req pulse during ACCESS is ignored.
